// File: rtl/rx_shift_ctrl.sv
// Receive sequencer for an async-serial frame: start detect, mid-bit shift strobes, stop check, buffer load.
// Latency: strobe k at t0+HALF+k*CLKS_PER_BIT after the sampled falling edge; load one cycle after the stop sample.
// Backpressure: none; a load while data_ready is still set raises the sticky overrun_error.
module rx_shift_ctrl #(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic data_read,
    output logic shift_strobe,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int CW   = $clog2(NUM_DATA_BITS + 1);

    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   bit_cnt_nxt;
    logic            prev;
    logic            armed;
    logic            start_edge;
    logic            stop_fail;

    // armed stays low after reset until the line has been seen idle, so a
    // line held low through reset cannot masquerade as a start bit.
    assign start_edge = armed & prev & ~serial_in;

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        bit_cnt_nxt  = bit_cnt;
        shift_strobe = 1'b0;
        load_buffer  = 1'b0;
        stop_fail    = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (start_edge) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (timer == T_HALF) begin
                    timer_nxt   = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = serial_in ? IDLE : DATA;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            DATA: begin
                if (timer == T_LAST) begin
                    shift_strobe = 1'b1;
                    timer_nxt    = '0;
                    bit_cnt_nxt  = bit_cnt + CW'(1);
                    if (bit_cnt == C_LAST) begin
                        state_nxt = STOP;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            STOP: begin
                if (timer == T_LAST) begin
                    timer_nxt = '0;
                    if (serial_in) begin
                        state_nxt = LOAD;
                    end else begin
                        stop_fail = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            LOAD: begin
                load_buffer = 1'b1;
                timer_nxt   = '0;
                state_nxt   = IDLE;
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            prev    <= 1'b1;
            armed   <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
            prev    <= serial_in;
            armed   <= armed | serial_in;
        end
    end

    // A flag set on the same edge as data_read takes priority over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (load_buffer) begin
                data_ready <= 1'b1;
            end else if (data_read) begin
                data_ready <= 1'b0;
            end

            if (stop_fail) begin
                framing_error <= 1'b1;
            end else if (data_read) begin
                framing_error <= 1'b0;
            end

            if (load_buffer && data_ready && !data_read) begin
                overrun_error <= 1'b1;
            end else if (data_read) begin
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_shift_ctrl.sv
// Builds a per-cycle stimulus timeline, predicts outputs with a frame-level model, then replays it against the DUT.
module tb_rx_shift_ctrl;

    localparam int CPB  = 10;
    localparam int N    = 8;
    localparam int HALF = CPB / 2;
    localparam int L    = 4000;

    logic clk = 1'b0;
    logic rst, serial_in, data_read;
    logic shift_strobe, load_buffer, data_ready, framing_error, overrun_error, busy;

    always #5 clk = ~clk;

    rx_shift_ctrl #(.CLKS_PER_BIT(CPB), .NUM_DATA_BITS(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .shift_strobe  (shift_strobe),
        .load_buffer   (load_buffer),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    typedef struct {
        int   cyc;
        int   sig;
        logic val;
    } dchk_t;

    logic       line_a [L];
    logic       rd_a   [L];
    logic       rs_a   [L];
    logic [7:0] fbyte  [L];
    logic       e_stb  [L];
    logic       e_ld   [L];
    logic       e_busy [L];
    logic       e_fail [L];
    logic       e_rdy  [L];
    logic       e_fe   [L];
    logic       e_ov   [L];
    logic [7:0] exp_q [$];
    dchk_t      dq [$];
    string      nm [6] = '{"strobe", "load", "ready", "ferr", "ovr", "busy"};

    int n_vec = 0;
    int n_err = 0;
    int cur   = 0;
    int p;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cur, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            line_a[p] = 1'b1;
            p++;
        end
    endtask

    task automatic low(input int n);
        for (int i = 0; i < n; i++) begin
            line_a[p] = 1'b0;
            p++;
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic stopb);
        fbyte[p] = b;
        low(CPB);
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < CPB; i++) begin
                line_a[p] = b[k];
                p++;
            end
        end
        for (int i = 0; i < CPB; i++) begin
            line_a[p] = stopb;
            p++;
        end
    endtask

    task automatic expect_at(input int cyc, input int sig, input logic val);
        dchk_t d;
        d.cyc = cyc;
        d.sig = sig;
        d.val = val;
        dq.push_back(d);
    endtask

    // Frame-level prediction: every accepted falling edge yields a fixed
    // schedule of strobes, a stop sample and either a load or a framing error.
    task automatic run_model();
        int c, t0, s, fin, lim;
        bit pv, arm, abort;
        bit r, f, o;
        for (int i = 0; i < L; i++) begin
            e_stb[i] = 0; e_ld[i] = 0; e_busy[i] = 0; e_fail[i] = 0;
        end
        c = 0; pv = 1; arm = 0;
        while (c < L) begin
            if (rs_a[c]) begin
                pv = 1; arm = 0; c++;
            end else if (arm && pv && !line_a[c]) begin
                t0 = c;
                s  = t0 + HALF + (N + 1) * CPB;
                if (line_a[t0 + HALF]) fin = t0 + HALF;
                else if (line_a[s])    fin = s + 1;
                else                   fin = s;
                lim = fin; abort = 0;
                for (int q = t0 + 1; q <= fin; q++) begin
                    if (rs_a[q] && !abort) begin
                        lim = q; abort = 1;
                    end
                end
                for (int q = t0 + 1; q <= lim; q++) e_busy[q] = 1;
                if (!line_a[t0 + HALF]) begin
                    for (int k = 1; k <= N; k++) begin
                        if (t0 + HALF + k * CPB <= lim) e_stb[t0 + HALF + k * CPB] = 1;
                    end
                    if (line_a[s]) begin
                        if (s + 1 <= lim) begin
                            e_ld[s + 1] = 1;
                            exp_q.push_back(fbyte[t0]);
                        end
                    end else if (s <= lim) begin
                        e_fail[s] = 1;
                    end
                end
                if (abort) c = lim;
                else begin
                    pv = line_a[fin];
                    c  = fin + 1;
                end
            end else begin
                arm = arm | line_a[c];
                pv  = line_a[c];
                c++;
            end
        end
        r = 0; f = 0; o = 0;
        for (int i = 0; i < L; i++) begin
            e_rdy[i] = r; e_fe[i] = f; e_ov[i] = o;
            if (rs_a[i]) begin
                r = 0; f = 0; o = 0;
            end else begin
                o = (e_ld[i] && r && !rd_a[i]) ? 1'b1 : (rd_a[i] ? 1'b0 : o);
                r = e_ld[i] ? 1'b1 : (rd_a[i] ? 1'b0 : r);
                f = e_fail[i] ? 1'b1 : (rd_a[i] ? 1'b0 : f);
            end
        end
    endtask

    task automatic build();
        int p5a, pg, pfe, pov, pnv, prs, prand, gap;
        logic sb;
        for (int i = 0; i < L; i++) begin
            line_a[i] = 1; rd_a[i] = 0; rs_a[i] = 0; fbyte[i] = 8'h00;
        end
        rs_a[0] = 1; rs_a[1] = 1;
        p = 2;
        idle(50);
        p5a = p; frame(8'h5A, 1'b1); idle(20); rd_a[p] = 1; idle(10);
        pg  = p; low(3); idle(20);
        pfe = p; frame(8'hC3, 1'b0); idle(20); rd_a[p] = 1; idle(10);
        pov = p; frame(8'h11, 1'b1); frame(8'h22, 1'b1); idle(20); rd_a[p] = 1; idle(10);
        pnv = p; frame(8'h33, 1'b1); frame(8'h44, 1'b1);
        rd_a[pnv + 196] = 1;
        idle(20); rd_a[p] = 1; idle(10);
        prs = p; low(70); rs_a[prs + 45] = 1; idle(30);
        frame(8'hA5, 1'b1); idle(20);

        expect_at(p5a + 14, 0, 0); expect_at(p5a + 15, 0, 1); expect_at(p5a + 85, 0, 1);
        expect_at(p5a + 96, 1, 1); expect_at(p5a + 96, 2, 0); expect_at(p5a + 97, 2, 1);
        expect_at(pg + 5, 5, 1);   expect_at(pg + 6, 5, 0);
        expect_at(pfe + 95, 3, 0); expect_at(pfe + 96, 3, 1); expect_at(pfe + 96, 1, 0);
        expect_at(pov + 197, 4, 1); expect_at(pov + 197, 2, 1);
        expect_at(pnv + 197, 4, 0); expect_at(pnv + 197, 2, 1);
        expect_at(prs + 45, 0, 1); expect_at(prs + 46, 5, 0); expect_at(prs + 60, 5, 0);

        prand = p;
        while (p < L - 300) begin
            if ($urandom_range(0, 9) == 0) begin
                low($urandom_range(1, 4));
                idle($urandom_range(1, 10));
            end else begin
                sb  = ($urandom_range(0, 4) != 0);
                frame(8'($urandom), sb);
                gap = sb ? $urandom_range(0, 12) : $urandom_range(1, 12);
                idle(gap);
            end
        end
        for (int i = prand; i < L; i++) begin
            if ($urandom_range(0, 15) == 0) rd_a[i] = 1;
        end
    endtask

    initial begin
        logic [7:0] sreg;
        logic [5:0] obs;
        sreg = 8'h00;
        rst = 1'b1; serial_in = 1'b1; data_read = 1'b0;
        build();
        run_model();
        @(posedge clk); #1;
        for (int c = 0; c < L; c++) begin
            cur       = c;
            rst       = rs_a[c];
            serial_in = line_a[c];
            data_read = rd_a[c];
            @(negedge clk);
            obs = {busy, overrun_error, framing_error, data_ready, load_buffer, shift_strobe};
            chk("strobe", 32'(shift_strobe),  32'(e_stb[c]));
            chk("load",   32'(load_buffer),   32'(e_ld[c]));
            chk("busy",   32'(busy),          32'(e_busy[c]));
            chk("ready",  32'(data_ready),    32'(e_rdy[c]));
            chk("ferr",   32'(framing_error), 32'(e_fe[c]));
            chk("ovr",    32'(overrun_error), 32'(e_ov[c]));
            foreach (dq[i]) begin
                if (dq[i].cyc == c) chk({"dir_", nm[dq[i].sig]}, 32'(obs[dq[i].sig]), 32'(dq[i].val));
            end
            if (load_buffer) begin
                if (exp_q.size() == 0) chk("load_unexp", 32'(1), 32'(0));
                else chk("rx_byte", 32'(sreg), 32'(exp_q.pop_front()));
            end
            if (shift_strobe) sreg = {serial_in, sreg[7:1]};
            @(posedge clk); #1;
        end
        chk("loads_left", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_shift_ctrl.md
Name: rx_shift_ctrl

Overview:
Receive-side sequencer for the flexible serial-to-parallel shift register. It detects an asynchronous-serial start bit and times each bit period. It issues one shift strobe per data bit at mid-bit, checks the stop bit, and then commands the downstream data buffer to load, with ready/error status. It sits between the synchronized serial line and the shift register / receive buffer.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit; legal values are >= 4. HALF = CLKS_PER_BIT/2, using integer division.
NUM_DATA_BITS, 8, data bits per frame; legal values are >= 1. It must equal the shift register's NUM_BITS.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
serial_in  input  1  serial line, already synchronized upstream; idle level 1. The block adds no synchronizer.
data_read  input  1  consumer pulse: clears data_ready and both error flags.
shift_strobe  output  1  one-cycle pulse; drives the shift register's shift_enable.
load_buffer  output  1  one-cycle pulse; the downstream buffer captures the shift register contents.
data_ready  output  1  sticky; a loaded byte is waiting to be read.
framing_error  output  1  sticky; the last frame's stop bit sampled 0.
overrun_error  output  1  sticky; a load occurred while data_ready was already 1.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; timer and bit count go to 0.
  - Previous-sample register goes to 1.
  - All outputs are 0.
  - Reset mid-frame abandons the frame; no load and no error.
  - A line held low through reset does not start a frame until it returns to 1 and falls again.
- Widths:
  - Timer is $clog2(CLKS_PER_BIT) bits.
  - Bit counter is $clog2(NUM_DATA_BITS+1) bits.
  - No wrap is reachable in legal operation.
- Registered outputs: shift_strobe and load_buffer are decoded from state/timer (Moore). data_ready and both error flags are registered.
- IDLE:
  - Go to START when the previous sample = 1 and serial_in = 0 (falling edge). Timer is 0 on entry.
- START:
  - Timer increments each cycle.
  - When timer = HALF-1, sample serial_in:
    - 0: go to DATA with timer 0 and bit count 0.
    - 1: treat as a glitch and return to IDLE, with no flags and no strobe.
- DATA:
  - Timer counts 0..CLKS_PER_BIT-1 and then reloads 0.
  - shift_strobe = 1 in the cycle where timer = CLKS_PER_BIT-1; bit count increments on that edge.
  - After the NUM_DATA_BITS-th strobe, go to STOP with timer 0.
- Strobe timing:
  - Let t0 be the cycle IDLE samples the falling edge.
  - Strobe k (k = 1..N) is asserted in cycle t0 + HALF + k*CLKS_PER_BIT.
- STOP:
  - When timer = CLKS_PER_BIT-1, sample serial_in (cycle t0 + HALF + (N+1)*CLKS_PER_BIT).
  - 1: go to LOAD.
  - 0: set framing_error, go to IDLE, no load. data_ready is unchanged.
- LOAD:
  - load_buffer = 1 for exactly one cycle; go to IDLE.
  - On that edge data_ready <= 1.
  - If data_ready was already 1 and data_read is not asserted that cycle, set overrun_error.
- IDLE re-entry: the previous-sample register updates every cycle. A start edge immediately after LOAD or STOP is accepted on the next cycle.
- data_read:
  - Clears data_ready, framing_error and overrun_error on the next edge.
  - If the same edge sets a flag (LOAD or stop-bit failure), the set wins. data_read during LOAD then yields data_ready = 1, overrun = 0.
- shift_strobe and load_buffer are never asserted in the same cycle. busy = 0 in IDLE only.

Test Plan:
- Reset, then line idle at 1 for 50 cycles -> all outputs 0, busy 0, no strobes.
- With CLKS_PER_BIT=10 and N=8, send frame 0x5A LSB-first with stop = 1, falling edge sampled at t0:
  - Strobes in cycles t0+15, 25, ..., 85 (8 pulses).
  - load_buffer at t0+96; data_ready = 1 from t0+97.
  - A paired 8-bit shift register (SHIFT_MSB = 0) holds 0x5A.
- Line low for 3 cycles then high (glitch) -> START rejects at t0+5, back to IDLE, zero strobes, no flags.
- Frame with stop bit = 0 -> 8 strobes, no load_buffer, framing_error = 1 at t0+96; a data_read pulse clears it.
- Two back-to-back valid frames with no data_read -> second load sets overrun_error = 1 with data_ready = 1. Repeat with data_read in the second LOAD cycle -> data_ready = 1, overrun = 0.
- Assert rst at strobe 4 mid-frame with the line held low -> outputs 0 next cycle. No new frame until the line goes 1 then 0; the subsequent frame is received correctly.
